// File: rtl/dispatch_queue_pkg.sv
// Shared widths, types and helpers for the dispatch queue between decode and RS/LSB.
package dispatch_queue_pkg;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned NUM_CDB   = 2;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_W     = 4;
  localparam int unsigned PAYLOAD_W = 96;
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned PTR_W     = IDX_W + 1;

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [ROB_W-1:0]     tag_t;
  typedef logic [PAYLOAD_W-1:0] payload_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [PTR_W-1:0]     ptr_t;

  // Result of matching one operand against all broadcast channels.
  typedef struct packed {
    logic  hit;
    data_t data;
  } snoop_t;

  // Same slot index but different wrap bit means every slot is occupied.
  function automatic logic ptr_full(ptr_t head, ptr_t tail);
    return (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Decode-side enqueue and RS/LSB-side dispatch signals of the dispatch queue.
interface dispatch_queue_if;
  import dispatch_queue_pkg::*;

  logic     in_valid;
  logic     in_ready;
  payload_t in_payload;
  logic     in_to_lsb;
  logic     in_rs1_pend;
  tag_t     in_rs1_tag;
  data_t    in_rs1_val;
  logic     in_rs2_pend;
  tag_t     in_rs2_tag;
  data_t    in_rs2_val;

  logic     out_rs_valid;
  logic     out_rs_ready;
  logic     out_lsb_valid;
  logic     out_lsb_ready;
  payload_t out_payload;
  logic     out_rs1_pend;
  tag_t     out_rs1_tag;
  data_t    out_rs1_val;
  logic     out_rs2_pend;
  tag_t     out_rs2_tag;
  data_t    out_rs2_val;

  // Environment side: decode offers entries, RS/LSB accept them.
  modport master (
    output in_valid, in_payload, in_to_lsb,
    output in_rs1_pend, in_rs1_tag, in_rs1_val,
    output in_rs2_pend, in_rs2_tag, in_rs2_val,
    output out_rs_ready, out_lsb_ready,
    input  in_ready, out_rs_valid, out_lsb_valid, out_payload,
    input  out_rs1_pend, out_rs1_tag, out_rs1_val,
    input  out_rs2_pend, out_rs2_tag, out_rs2_val
  );

  // Queue side.
  modport slave (
    input  in_valid, in_payload, in_to_lsb,
    input  in_rs1_pend, in_rs1_tag, in_rs1_val,
    input  in_rs2_pend, in_rs2_tag, in_rs2_val,
    input  out_rs_ready, out_lsb_ready,
    output in_ready, out_rs_valid, out_lsb_valid, out_payload,
    output out_rs1_pend, out_rs1_tag, out_rs1_val,
    output out_rs2_pend, out_rs2_tag, out_rs2_val
  );

endinterface

// File: rtl/dispatch_queue_cdb_snoop.sv
// Matches one pending operand against all CDB channels; the lowest-numbered matching channel wins.
module dispatch_queue_cdb_snoop
  import dispatch_queue_pkg::*;
(
  input  logic                      pend,
  input  tag_t                      tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output snoop_t                    res_c
);

  // Scan high to low so the lowest matching channel is written last.
  always_comb begin
    res_c = '0;
    for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
      if (pend && cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == tag)) begin
        res_c.hit  = 1'b1;
        res_c.data = cdb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions, resolves operands from the CDB while queued,
// and steers the head entry to the RS or LSB.
module dispatch_queue
  import dispatch_queue_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rollback,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  dispatch_queue_if.slave           dq
);

  ptr_t     head_q, head_d, tail_q, tail_d;
  logic     valid_q    [DEPTH];
  logic     valid_d    [DEPTH];
  payload_t payload_q  [DEPTH];
  payload_t payload_d  [DEPTH];
  logic     to_lsb_q   [DEPTH];
  logic     to_lsb_d   [DEPTH];
  logic     rs1_pend_q [DEPTH];
  logic     rs1_pend_d [DEPTH];
  tag_t     rs1_tag_q  [DEPTH];
  tag_t     rs1_tag_d  [DEPTH];
  data_t    rs1_val_q  [DEPTH];
  data_t    rs1_val_d  [DEPTH];
  logic     rs2_pend_q [DEPTH];
  logic     rs2_pend_d [DEPTH];
  tag_t     rs2_tag_q  [DEPTH];
  tag_t     rs2_tag_d  [DEPTH];
  data_t    rs2_val_q  [DEPTH];
  data_t    rs2_val_d  [DEPTH];

  snoop_t   rs1_snp [DEPTH];
  snoop_t   rs2_snp [DEPTH];
  snoop_t   in_rs1_snp, in_rs2_snp;

  idx_t     head_idx_c, tail_idx_c;
  logic     empty_c, full_c, enq_c, deq_c;
  logic     in_ready_c, rs_valid_c, lsb_valid_c;

  // One snooper per stored operand.
  for (genvar e = 0; e < DEPTH; e++) begin : g_snoop
    dispatch_queue_cdb_snoop u_rs1 (
      .pend(rs1_pend_q[e]), .tag(rs1_tag_q[e]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .res_c(rs1_snp[e])
    );
    dispatch_queue_cdb_snoop u_rs2 (
      .pend(rs2_pend_q[e]), .tag(rs2_tag_q[e]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .res_c(rs2_snp[e])
    );
  end

  // The incoming entry is snooped too, so a broadcast in its enqueue cycle is not lost.
  dispatch_queue_cdb_snoop u_in_rs1 (
    .pend(dq.in_rs1_pend), .tag(dq.in_rs1_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_c(in_rs1_snp)
  );
  dispatch_queue_cdb_snoop u_in_rs2 (
    .pend(dq.in_rs2_pend), .tag(dq.in_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_c(in_rs2_snp)
  );

  // Handshake qualification.
  always_comb begin : handshake
    head_idx_c  = head_q[IDX_W-1:0];
    tail_idx_c  = tail_q[IDX_W-1:0];
    empty_c     = (head_q == tail_q);
    full_c      = ptr_full(head_q, tail_q);
    in_ready_c  = rdy && !rollback && !full_c;
    rs_valid_c  = rdy && !rollback && !empty_c && !to_lsb_q[head_idx_c];
    lsb_valid_c = rdy && !rollback && !empty_c &&  to_lsb_q[head_idx_c];
    enq_c       = dq.in_valid && in_ready_c;
    deq_c       = (rs_valid_c && dq.out_rs_ready) || (lsb_valid_c && dq.out_lsb_ready);
  end

  // Head fields with same-cycle CDB bypass so a dispatched entry never misses a broadcast.
  always_comb begin : head_out
    dq.in_ready      = in_ready_c;
    dq.out_rs_valid  = rs_valid_c;
    dq.out_lsb_valid = lsb_valid_c;
    dq.out_payload   = payload_q[head_idx_c];
    dq.out_rs1_tag   = rs1_tag_q[head_idx_c];
    dq.out_rs2_tag   = rs2_tag_q[head_idx_c];
    dq.out_rs1_pend  = rs1_pend_q[head_idx_c] && !rs1_snp[head_idx_c].hit;
    dq.out_rs2_pend  = rs2_pend_q[head_idx_c] && !rs2_snp[head_idx_c].hit;
    dq.out_rs1_val   = rs1_snp[head_idx_c].hit ? rs1_snp[head_idx_c].data : rs1_val_q[head_idx_c];
    dq.out_rs2_val   = rs2_snp[head_idx_c].hit ? rs2_snp[head_idx_c].data : rs2_val_q[head_idx_c];
  end

  always_comb begin : next_state
    head_d = head_q;
    tail_d = tail_q;
    for (int e = 0; e < DEPTH; e++) begin
      valid_d[e]    = valid_q[e];
      payload_d[e]  = payload_q[e];
      to_lsb_d[e]   = to_lsb_q[e];
      rs1_pend_d[e] = rs1_pend_q[e];
      rs1_tag_d[e]  = rs1_tag_q[e];
      rs1_val_d[e]  = rs1_val_q[e];
      rs2_pend_d[e] = rs2_pend_q[e];
      rs2_tag_d[e]  = rs2_tag_q[e];
      rs2_val_d[e]  = rs2_val_q[e];
    end

    if (rdy) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (valid_q[e] && rs1_snp[e].hit) begin
          rs1_pend_d[e] = 1'b0;
          rs1_val_d[e]  = rs1_snp[e].data;
        end
        if (valid_q[e] && rs2_snp[e].hit) begin
          rs2_pend_d[e] = 1'b0;
          rs2_val_d[e]  = rs2_snp[e].data;
        end
      end

      if (enq_c) begin
        valid_d[tail_idx_c]    = 1'b1;
        payload_d[tail_idx_c]  = dq.in_payload;
        to_lsb_d[tail_idx_c]   = dq.in_to_lsb;
        rs1_tag_d[tail_idx_c]  = dq.in_rs1_tag;
        rs2_tag_d[tail_idx_c]  = dq.in_rs2_tag;
        rs1_pend_d[tail_idx_c] = dq.in_rs1_pend && !in_rs1_snp.hit;
        rs2_pend_d[tail_idx_c] = dq.in_rs2_pend && !in_rs2_snp.hit;
        rs1_val_d[tail_idx_c]  = in_rs1_snp.hit ? in_rs1_snp.data : dq.in_rs1_val;
        rs2_val_d[tail_idx_c]  = in_rs2_snp.hit ? in_rs2_snp.data : dq.in_rs2_val;
        tail_d                 = tail_q + PTR_W'(1);
      end

      if (deq_c) begin
        valid_d[head_idx_c] = 1'b0;
        head_d              = head_q + PTR_W'(1);
      end

      // Rollback squashes everything; handshakes are already blocked this cycle.
      if (rollback) begin
        head_d = '0;
        tail_d = '0;
        for (int e = 0; e < DEPTH; e++) valid_d[e] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin : regs
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e]    <= 1'b0;
        payload_q[e]  <= '0;
        to_lsb_q[e]   <= 1'b0;
        rs1_pend_q[e] <= 1'b0;
        rs1_tag_q[e]  <= '0;
        rs1_val_q[e]  <= '0;
        rs2_pend_q[e] <= 1'b0;
        rs2_tag_q[e]  <= '0;
        rs2_val_q[e]  <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int e = 0; e < DEPTH; e++) begin
        valid_q[e]    <= valid_d[e];
        payload_q[e]  <= payload_d[e];
        to_lsb_q[e]   <= to_lsb_d[e];
        rs1_pend_q[e] <= rs1_pend_d[e];
        rs1_tag_q[e]  <= rs1_tag_d[e];
        rs1_val_q[e]  <= rs1_val_d[e];
        rs2_pend_q[e] <= rs2_pend_d[e];
        rs2_tag_q[e]  <= rs2_tag_d[e];
        rs2_val_q[e]  <= rs2_val_d[e];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      rdy;
  logic                      rollback;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*ROB_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;

  dispatch_queue_if dq();

  dispatch_queue u_dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .dq(dq)
  );

  always #5 clk = ~clk;

  typedef struct {
    payload_t payload;
    logic     to_lsb;
    logic     p1;
    tag_t     t1;
    data_t    v1;
    logic     p2;
    tag_t     t2;
    data_t    v2;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // First valid channel carrying the operand's tag supplies the value.
  function automatic void op_resolve(input logic p, input tag_t t, input data_t v,
                                     output logic po, output data_t vo);
    po = p;
    vo = v;
    for (int i = 0; i < NUM_CDB; i++)
      if (po && cdb_valid[i] && cdb_tag[i*ROB_W +: ROB_W] == t) begin
        po = 1'b0;
        vo = cdb_data[i*DATA_W +: DATA_W];
      end
  endfunction

  function automatic ent_t snoop_ent(input ent_t e);
    ent_t r;
    r = e;
    op_resolve(e.p1, e.t1, e.v1, r.p1, r.v1);
    op_resolve(e.p2, e.t2, e.v2, r.p2, r.v2);
    return r;
  endfunction

  function automatic ent_t in_ent();
    ent_t r;
    r.payload = dq.in_payload;  r.to_lsb = dq.in_to_lsb;
    r.p1 = dq.in_rs1_pend;  r.t1 = dq.in_rs1_tag;  r.v1 = dq.in_rs1_val;
    r.p2 = dq.in_rs2_pend;  r.t2 = dq.in_rs2_tag;  r.v2 = dq.in_rs2_val;
    return r;
  endfunction

  // Queue semantics applied at the coming clock edge.
  function automatic void model_edge();
    logic deq;
    logic enq;
    ent_t ni;
    if (!rdy) return;
    if (rollback) begin
      mq.delete();
      return;
    end
    deq = (mq.size() > 0) && (mq[0].to_lsb ? dq.out_lsb_ready : dq.out_rs_ready);
    enq = dq.in_valid && (mq.size() < DEPTH);
    ni  = snoop_ent(in_ent());
    foreach (mq[k]) mq[k] = snoop_ent(mq[k]);
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(ni);
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input payload_t pl, input logic lsb, input logic p1, input tag_t t1,
                        input data_t v1, input logic p2, input tag_t t2, input data_t v2);
    dq.in_payload = pl;  dq.in_to_lsb = lsb;
    dq.in_rs1_pend = p1; dq.in_rs1_tag = t1; dq.in_rs1_val = v1;
    dq.in_rs2_pend = p2; dq.in_rs2_tag = t2; dq.in_rs2_val = v2;
  endtask

  task automatic rand_in(input logic lsb);
    set_in({$urandom(), $urandom(), $urandom()}, lsb,
           1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 3)), $urandom(),
           1'($urandom_range(0, 1)), ROB_W'($urandom_range(0, 3)), $urandom());
  endtask

  task automatic set_cdb(input logic [NUM_CDB-1:0] v, input tag_t t0, input data_t d0,
                         input tag_t t1, input data_t d1);
    cdb_valid = v;
    cdb_tag   = {t1, t0};
    cdb_data  = {d1, d0};
  endtask

  task automatic clear_inputs();
    rdy = 1'b1;  rollback = 1'b0;
    dq.in_valid = 1'b0;  dq.out_rs_ready = 1'b0;  dq.out_lsb_ready = 1'b0;
    set_in('0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    set_cdb('0, '0, '0, '0, '0);
  endtask

  task automatic flush();
    clear_inputs();
    rollback = 1'b1;
    #1;
    step();
    rollback = 1'b0;
  endtask

  task automatic enq_one();
    dq.in_valid = 1'b1;
    #1;
    step();
    dq.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dq.out_rs_valid !== 1'b0 || dq.out_lsb_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_valids: got %b%b required 00", dq.out_rs_valid, dq.out_lsb_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (dq.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_in_ready: got %b required 1", dq.in_ready); end
    n_cmp++; if (dq.out_payload !== '0 || dq.out_rs1_val !== '0 || dq.out_rs2_tag !== '0 ||
                 dq.out_rs1_pend !== 1'b0) begin n_bad++;
      $display("FAIL reset_fields: payload %h rs1_val %h rs2_tag %h required 0",
               dq.out_payload, dq.out_rs1_val, dq.out_rs2_tag); end
    mq.delete();
  endtask

  task automatic test_fill();
    int seen;
    flush();
    for (int k = 0; k < DEPTH; k++) begin
      rand_in(1'($urandom_range(0, 1)));
      dq.in_valid = 1'b1;
      #1;
      n_cmp++; if (dq.in_ready !== 1'b1) begin n_bad++;
        $display("FAIL fill_in_ready_%0d: got %b required 1", k, dq.in_ready); end
      step();
    end
    rand_in(1'b0);
    #1;
    n_cmp++; if (dq.in_ready !== 1'b0) begin n_bad++;
      $display("FAIL fill_full_in_ready: got %b required 0", dq.in_ready); end
    step();
    dq.in_valid = 1'b0;  dq.out_rs_ready = 1'b1;  dq.out_lsb_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      #1;
      if (dq.out_rs_valid || dq.out_lsb_valid) begin
        seen++;
        n_cmp++; if (mq.size() == 0 || dq.out_payload !== mq[0].payload) begin n_bad++;
          $display("FAIL fill_drain_payload: got %h", dq.out_payload); end
      end
      step();
    end
    n_cmp++; if (seen != DEPTH) begin n_bad++;
      $display("FAIL fill_count: drained %0d required %0d", seen, DEPTH); end
  endtask

  task automatic test_order();
    flush();
    set_in(payload_t'(32'h100), 1'b0, 1'b0, '0, 32'h1, 1'b0, '0, 32'h2);
    dq.in_valid = 1'b1;
    #1;
    n_cmp++; if (dq.out_rs_valid !== 1'b0) begin n_bad++;
      $display("FAIL order_no_flow_through: rs_valid %b required 0", dq.out_rs_valid); end
    step();
    set_in(payload_t'(32'h104), 1'b1, 1'b0, '0, 32'h3, 1'b0, '0, 32'h4);
    #1;
    n_cmp++; if (dq.out_rs_valid !== 1'b1 || dq.out_lsb_valid !== 1'b0 ||
                 dq.out_payload[31:0] !== 32'h100) begin n_bad++;
      $display("FAIL order_rs_first: rs %b lsb %b pc %h required 1 0 100",
               dq.out_rs_valid, dq.out_lsb_valid, dq.out_payload[31:0]); end
    step();
    dq.in_valid = 1'b0;  dq.out_rs_ready = 1'b1;
    #1;
    step();
    dq.out_rs_ready = 1'b0;
    #1;
    n_cmp++; if (dq.out_lsb_valid !== 1'b1 || dq.out_rs_valid !== 1'b0 ||
                 dq.out_payload[31:0] !== 32'h104) begin n_bad++;
      $display("FAIL order_lsb_next: rs %b lsb %b pc %h required 0 1 104",
               dq.out_rs_valid, dq.out_lsb_valid, dq.out_payload[31:0]); end
  endtask

  task automatic test_snoop();
    flush();
    set_in(payload_t'(1), 1'b0, 1'b0, '0, 32'h5, 1'b0, '0, 32'h6);
    enq_one();
    set_in(payload_t'(2), 1'b0, 1'b1, 4'd3, 32'h0, 1'b0, 4'd3, 32'h77);
    enq_one();
    set_cdb(2'b01, 4'd3, 32'hDEAD, 4'd9, 32'hBEEF);
    #1;
    step();
    set_cdb('0, '0, '0, '0, '0);
    dq.out_rs_ready = 1'b1;
    #1;
    step();
    dq.out_rs_ready = 1'b0;
    #1;
    n_cmp++; if (dq.out_rs1_pend !== 1'b0 || dq.out_rs1_val !== 32'hDEAD ||
                 dq.out_rs2_val !== 32'h77) begin n_bad++;
      $display("FAIL snoop_stored: pend %b val %h rs2 %h required 0 dead 77",
               dq.out_rs1_pend, dq.out_rs1_val, dq.out_rs2_val); end
    dq.out_rs_ready = 1'b1;
    #1;
    step();
    dq.out_rs_ready = 1'b0;
    set_in(payload_t'(3), 1'b0, 1'b1, 4'd3, 32'h0, 1'b0, '0, 32'h0);
    enq_one();
    set_cdb(2'b01, 4'd3, 32'hDEAD, 4'd9, 32'hBEEF);
    dq.out_rs_ready = 1'b1;
    #1;
    n_cmp++; if (dq.out_rs_valid !== 1'b1 || dq.out_rs1_pend !== 1'b0 ||
                 dq.out_rs1_val !== 32'hDEAD) begin n_bad++;
      $display("FAIL snoop_bypass: valid %b pend %b val %h required 1 0 dead",
               dq.out_rs_valid, dq.out_rs1_pend, dq.out_rs1_val); end
    step();
    set_cdb('0, '0, '0, '0, '0);
    dq.out_rs_ready = 1'b0;
    #1;
    n_cmp++; if (dq.out_rs_valid !== 1'b0) begin n_bad++;
      $display("FAIL snoop_dispatched: rs_valid %b required 0", dq.out_rs_valid); end
  endtask

  task automatic test_priority();
    flush();
    set_in(payload_t'(4), 1'b0, 1'b0, '0, 32'h0, 1'b1, 4'd5, 32'h0);
    set_cdb(2'b11, 4'd5, 32'h11, 4'd5, 32'h22);
    enq_one();
    set_cdb('0, '0, '0, '0, '0);
    #1;
    n_cmp++; if (dq.out_rs2_pend !== 1'b0 || dq.out_rs2_val !== 32'h11) begin n_bad++;
      $display("FAIL prio_incoming: pend %b val %h required 0 11", dq.out_rs2_pend, dq.out_rs2_val); end
    dq.out_rs_ready = 1'b1;
    step();
    dq.out_rs_ready = 1'b0;
    set_in(payload_t'(5), 1'b1, 1'b1, 4'd5, 32'h0, 1'b0, '0, 32'h0);
    enq_one();
    set_cdb(2'b11, 4'd5, 32'h11, 4'd5, 32'h22);
    #1;
    n_cmp++; if (dq.out_rs1_pend !== 1'b0 || dq.out_rs1_val !== 32'h11) begin n_bad++;
      $display("FAIL prio_bypass: pend %b val %h required 0 11", dq.out_rs1_pend, dq.out_rs1_val); end
    step();
    set_cdb('0, '0, '0, '0, '0);
    #1;
    n_cmp++; if (dq.out_rs1_pend !== 1'b0 || dq.out_rs1_val !== 32'h11) begin n_bad++;
      $display("FAIL prio_stored: pend %b val %h required 0 11", dq.out_rs1_pend, dq.out_rs1_val); end
  endtask

  task automatic test_rollback();
    flush();
    for (int k = 0; k < 5; k++) begin
      rand_in(1'($urandom_range(0, 1)));
      enq_one();
    end
    rand_in(1'b0);
    dq.in_valid = 1'b1;  rollback = 1'b1;
    dq.out_rs_ready = 1'b1;  dq.out_lsb_ready = 1'b1;
    #1;
    n_cmp++; if (dq.in_ready !== 1'b0 || dq.out_rs_valid !== 1'b0 || dq.out_lsb_valid !== 1'b0) begin
      n_bad++; $display("FAIL rollback_cycle: in_ready %b rs %b lsb %b required 0 0 0",
                        dq.in_ready, dq.out_rs_valid, dq.out_lsb_valid); end
    step();
    rollback = 1'b0;  dq.in_valid = 1'b0;
    #1;
    n_cmp++; if (dq.in_ready !== 1'b1 || dq.out_rs_valid !== 1'b0 || dq.out_lsb_valid !== 1'b0) begin
      n_bad++; $display("FAIL rollback_after: in_ready %b rs %b lsb %b required 1 0 0",
                        dq.in_ready, dq.out_rs_valid, dq.out_lsb_valid); end
    dq.out_rs_ready = 1'b0;  dq.out_lsb_ready = 1'b0;
  endtask

  task automatic test_freeze_and_async_reset();
    ent_t h;
    flush();
    for (int k = 0; k < DEPTH; k++) begin
      rand_in(1'($urandom_range(0, 1)));
      enq_one();
    end
    for (int c = 0; c < 3; c++) begin
      rdy = 1'b0;  dq.in_valid = 1'b1;  dq.out_rs_ready = 1'b1;  dq.out_lsb_ready = 1'b1;
      set_cdb(2'b11, ROB_W'($urandom_range(0, 3)), $urandom(), ROB_W'($urandom_range(0, 3)), $urandom());
      #1;
      n_cmp++; if (dq.in_ready !== 1'b0 || dq.out_rs_valid !== 1'b0 || dq.out_lsb_valid !== 1'b0) begin
        n_bad++; $display("FAIL freeze_cycle_%0d: in_ready %b rs %b lsb %b required 0 0 0",
                          c, dq.in_ready, dq.out_rs_valid, dq.out_lsb_valid); end
      step();
    end
    rdy = 1'b1;  dq.in_valid = 1'b0;
    set_cdb('0, '0, '0, '0, '0);
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      h = mq[0];
      n_cmp++; if (dq.out_payload !== h.payload || dq.out_rs1_pend !== h.p1 || dq.out_rs1_val !== h.v1 ||
                   dq.out_rs2_pend !== h.p2 || dq.out_rs2_val !== h.v2 ||
                   dq.out_lsb_valid !== h.to_lsb) begin n_bad++;
        $display("FAIL freeze_entry_%0d: payload %h p1 %b v1 %h p2 %b v2 %h required %h %b %h %b %h",
                 c, dq.out_payload, dq.out_rs1_pend, dq.out_rs1_val, dq.out_rs2_pend, dq.out_rs2_val,
                 h.payload, h.p1, h.v1, h.p2, h.v2); end
      step();
    end
    dq.out_rs_ready = 1'b0;  dq.out_lsb_ready = 1'b0;
    rand_in(1'b0);
    enq_one();
    rand_in(1'b1);
    enq_one();
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (dq.out_rs_valid !== 1'b0 || dq.out_lsb_valid !== 1'b0 || dq.out_payload !== '0) begin
      n_bad++; $display("FAIL async_reset: rs %b lsb %b payload %h required 0 0 0",
                        dq.out_rs_valid, dq.out_lsb_valid, dq.out_payload); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mq.delete();
    #1;
    n_cmp++; if (dq.in_ready !== 1'b1 || dq.out_rs_valid !== 1'b0) begin n_bad++;
      $display("FAIL async_reset_release: in_ready %b rs %b required 1 0", dq.in_ready, dq.out_rs_valid); end
  endtask

  task automatic test_random();
    ent_t h;
    logic e_ready;
    flush();
    for (int c = 0; c < 400; c++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      rand_in(1'($urandom_range(0, 1)));
      dq.in_valid      = 1'($urandom_range(0, 1));
      dq.out_rs_ready  = 1'($urandom_range(0, 1));
      dq.out_lsb_ready = 1'($urandom_range(0, 1));
      set_cdb(2'($urandom_range(0, 3)), ROB_W'($urandom_range(0, 3)), $urandom(),
              ROB_W'($urandom_range(0, 3)), $urandom());
      #1;
      e_ready = rdy && !rollback && (mq.size() < DEPTH);
      n_cmp++; if (dq.in_ready !== e_ready) begin n_bad++;
        $display("FAIL rand_in_ready_%0d: got %b required %b", c, dq.in_ready, e_ready); end
      if (rdy && !rollback && mq.size() > 0) begin
        h = snoop_ent(mq[0]);
        n_cmp++; if (dq.out_rs_valid !== !h.to_lsb || dq.out_lsb_valid !== h.to_lsb) begin n_bad++;
          $display("FAIL rand_valids_%0d: rs %b lsb %b to_lsb %b", c, dq.out_rs_valid,
                   dq.out_lsb_valid, h.to_lsb); end
        n_cmp++; if (dq.out_payload !== h.payload || dq.out_rs1_pend !== h.p1 || dq.out_rs1_val !== h.v1 ||
                     dq.out_rs1_tag !== h.t1 || dq.out_rs2_pend !== h.p2 || dq.out_rs2_val !== h.v2 ||
                     dq.out_rs2_tag !== h.t2) begin n_bad++;
          $display("FAIL rand_head_%0d: p1 %b v1 %h p2 %b v2 %h required %b %h %b %h", c,
                   dq.out_rs1_pend, dq.out_rs1_val, dq.out_rs2_pend, dq.out_rs2_val,
                   h.p1, h.v1, h.p2, h.v2); end
      end else begin
        n_cmp++; if (dq.out_rs_valid !== 1'b0 || dq.out_lsb_valid !== 1'b0) begin n_bad++;
          $display("FAIL rand_idle_%0d: rs %b lsb %b required 0 0", c, dq.out_rs_valid,
                   dq.out_lsb_valid); end
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_order();
    test_snoop();
    test_priority();
    test_rollback();
    test_freeze_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
